img_bram_arbiter: RTL

Shares the single write/read port of the 128×128 8-bit image BRAM (16384 entries) between three requesters:
- the UART pixel loader (write-only);
- the SIFT processing reader (read port 0);
- the image transmitter (read port 1).

It sits between those blocks and the BRAM port, grants at most one access per cycle, and routes read data back to the requester that issued it. This lets receive, processing and send share one port without external sequencing.

---
 rtl/img_arb_pkg.sv | 15 +
 rtl/img_bram_arbiter_tag_pipe.sv | 26 ++
 rtl/img_bram_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/img_arb_pkg.sv
// Shared types and default geometry for the image BRAM arbiter.
package img_arb_pkg;

   localparam int IMG_ADDR_W        = 14;
   localparam int IMG_DATA_W        = 8;
   localparam int BRAM_READ_LATENCY = 2;

   typedef enum logic [1:0] {
      TAG_NONE,
      TAG_WR,
      TAG_RD0,
      TAG_RD1
   } arb_tag_t;

endpackage

// File: rtl/img_bram_arbiter_tag_pipe.sv
// Fixed-depth shift register of access tags; reset flushes every stage to TAG_NONE.
module arb_tag_pipe
   import img_arb_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic     clk,
   input  logic     rst_in,
   input  arb_tag_t tag_in,
   output arb_tag_t tag_out
);

   arb_tag_t tag_p [DEPTH];

   always_ff @(posedge clk) begin
      if (rst_in) begin
         for (int i = 0; i < DEPTH; i++) tag_p[i] <= TAG_NONE;
      end else begin
         tag_p[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) tag_p[i] <= tag_p[i-1];
      end
   end

   assign tag_out = tag_p[DEPTH-1];

endmodule

// File: rtl/img_bram_arbiter.sv
// Shares one BRAM port between the pixel loader (write) and two readers;
// the writer always wins, the readers alternate, read data is routed back by tag.
module img_bram_arbiter
   import img_arb_pkg::*;
#(
   parameter int ADDR_W       = IMG_ADDR_W,
   parameter int DATA_W       = IMG_DATA_W,
   parameter int READ_LATENCY = BRAM_READ_LATENCY
) (
   input  logic              clk,
   input  logic              rst_in,
   input  logic              wr_req_in,
   input  logic [ADDR_W-1:0] wr_addr_in,
   input  logic [DATA_W-1:0] wr_data_in,
   output logic              wr_gnt_out,
   input  logic              rd0_req_in,
   input  logic [ADDR_W-1:0] rd0_addr_in,
   output logic              rd0_gnt_out,
   output logic              rd0_valid_out,
   output logic [DATA_W-1:0] rd0_data_out,
   input  logic              rd1_req_in,
   input  logic [ADDR_W-1:0] rd1_addr_in,
   output logic              rd1_gnt_out,
   output logic              rd1_valid_out,
   output logic [DATA_W-1:0] rd1_data_out,
   output logic [ADDR_W-1:0] bram_addr_out,
   output logic [DATA_W-1:0] bram_din_out,
   output logic              bram_we_out,
   input  logic [DATA_W-1:0] bram_dout_in
);

   // 0 = rd0 was granted last, 1 = rd1 was granted last
   logic     last_rd;
   arb_tag_t tag_p0;
   arb_tag_t tag_ret;

   // Grants are suppressed during reset so no access is promised and then lost.
   always_comb begin
      wr_gnt_out  = ~rst_in & wr_req_in;
      rd0_gnt_out = ~rst_in & ~wr_req_in & rd0_req_in & (~rd1_req_in | last_rd);
      rd1_gnt_out = ~rst_in & ~wr_req_in & rd1_req_in & (~rd0_req_in | ~last_rd);
   end

   always_comb begin
      tag_p0 = TAG_NONE;
      if (wr_gnt_out)       tag_p0 = TAG_WR;
      else if (rd0_gnt_out) tag_p0 = TAG_RD0;
      else if (rd1_gnt_out) tag_p0 = TAG_RD1;
   end

   // Stage boundary: granted request drives the BRAM port one cycle later
   always_ff @(posedge clk) begin
      if (rst_in) begin
         bram_addr_out <= '0;
         bram_din_out  <= '0;
         bram_we_out   <= 1'b0;
         last_rd       <= 1'b1;
      end else begin
         bram_we_out <= wr_gnt_out;
         if (wr_gnt_out) begin
            bram_addr_out <= wr_addr_in;
            bram_din_out  <= wr_data_in;
         end else if (rd0_gnt_out) begin
            bram_addr_out <= rd0_addr_in;
            last_rd       <= 1'b0;
         end else if (rd1_gnt_out) begin
            bram_addr_out <= rd1_addr_in;
            last_rd       <= 1'b1;
         end
      end
   end

   // One extra stage covers the port register in front of the BRAM latency.
   arb_tag_pipe #(
      .DEPTH (READ_LATENCY + 1)
   ) u_tag_pipe (
      .clk     (clk),
      .rst_in  (rst_in),
      .tag_in  (tag_p0),
      .tag_out (tag_ret)
   );

   // Stage boundary: returning tag steers BRAM output to the owning reader
   always_ff @(posedge clk) begin
      if (rst_in) begin
         rd0_valid_out <= 1'b0;
         rd1_valid_out <= 1'b0;
         rd0_data_out  <= '0;
         rd1_data_out  <= '0;
      end else begin
         rd0_valid_out <= (tag_ret == TAG_RD0);
         rd1_valid_out <= (tag_ret == TAG_RD1);
         if (tag_ret == TAG_RD0) rd0_data_out <= bram_dout_in;
         if (tag_ret == TAG_RD1) rd1_data_out <= bram_dout_in;
      end
   end

endmodule
